ffs_rr_arbiter_m: RTL

Round-robin arbiter that shares one resource among N requesters, using the team's find-first-set block as its priority encoder. A registered last-grant pointer rotates priority after every grant. Grants are held until the owner drops its request, or until an optional hold limit expires while others are waiting. The block sits between requester agents and any shared datapath that must be owned by one agent at a time.

---
 rtl/ffs_rr_arbiter_m.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ffs_rr_arbiter_m.sv
// Round-robin arbiter over N requesters: two find-first-set searches (masked above the
// last-grant pointer, then unmasked) choose the next owner; optional hold-limit preemption.

module ffs_m #(
    parameter int N = 8
) (
    input  logic [N-1:0]         vec,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);
    localparam int IW = $clog2(N);

    // Scan downward so the lowest set bit is the last assignment and wins.
    always_comb begin
        idx   = '0;
        found = |vec;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i[IW-1:0];
            end
        end
    end
endmodule

module ffs_rr_arbiter_m #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 grant_valid
);
    localparam int IW = $clog2(N);
    localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [N-1:0]    above_ptr;
    logic [N-1:0]    cand;
    logic [IW-1:0]   masked_idx, full_idx, win;
    logic            masked_found, full_found, win_valid;
    logic            hold_expired;
    logic            take;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mask
            assign above_ptr[gi] = (ptr_q < IW'(gi));
        end
    endgenerate

    // The current owner never competes against itself for a hand-off.
    assign cand = (state_q == GRANT) ? (req & ~grant_q) : req;

    ffs_m #(.N(N)) u_ffs_masked (
        .vec   (cand & above_ptr),
        .idx   (masked_idx),
        .found (masked_found)
    );

    ffs_m #(.N(N)) u_ffs_full (
        .vec   (cand),
        .idx   (full_idx),
        .found (full_found)
    );

    assign win          = masked_found ? masked_idx : full_idx;
    assign win_valid    = full_found;
    assign hold_expired = (MAX_HOLD != 0) && (cnt_q >= CW'(MAX_HOLD));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        take       = 1'b0;

        case (state_q)
            IDLE: begin
                take = win_valid;
            end
            GRANT: begin
                if (!req[grant_id_q]) begin
                    if (win_valid) begin
                        take = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        grant_id_d = '0;
                    end
                end else if (hold_expired && win_valid) begin
                    take = 1'b1;
                end else if ((MAX_HOLD != 0) && (cnt_q < CW'(MAX_HOLD))) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                grant_d    = '0;
                grant_id_d = '0;
            end
        endcase

        if (take) begin
            state_d      = GRANT;
            grant_d      = '0;
            grant_d[win] = 1'b1;
            grant_id_d   = win;
            ptr_d        = win;
            cnt_d        = CW'(1);
        end
    end

    // Pointer resets to N-1 so index 0 is first in line after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            ptr_q      <= '1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = (state_q == GRANT);
endmodule
